// File: rtl/seg_disp_pkg.sv
// Shared definitions for the BCD 7-segment display driver.
//   SEG_BLANK / SEG_DASH : active-low segment patterns (bit0=a .. bit6=g, 0=lit)
//   state_t              : control FSM states of bcd_display_driver
//   bcd_to_seg()         : BCD nibble -> active-low segments, codes >9 blank
package seg_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_digit_encode.sv
// One decimal digit -> active-low 7-segment pattern (purely combinational).
//   digit_i : BCD nibble
//   seg_o   : segments, bit0=a .. bit6=g, 0=lit; non-decimal codes blank
module seg7_digit_encode
    import seg_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = bcd_to_seg(digit_i);

endmodule

// File: rtl/bcd_display_driver.sv
// Binary value -> NUM_DIGITS active-low 7-segment displays.
// Conversion is sequential double-dabble, one input bit per clock.
//
// Ports:
//   clk         : clock, all state on rising edge
//   reset_n     : asynchronous active-low reset
//   in_valid    : in_data holds a value to display
//   in_data     : unsigned binary value (DATA_W bits)
//   in_ready    : driver idle
//   hex         : segments, digit k at [7k+6:7k], 0=lit
//   overflow    : last accepted value exceeded 10^NUM_DIGITS-1
//   disp_update : one-cycle pulse after hex/overflow take a new value
//
// Handshake: a value is accepted on a rising edge where in_valid & in_ready;
// in_valid is ignored while busy, so the source holds the value until in_ready.
//
// Build option: define LEADING_ZERO_BLANK_EN to blank digits above the most
// significant nonzero digit (digit 0 always shown, never applied to dashes).
module bcd_display_driver
    import seg_disp_pkg::*;
#(
    parameter int DATA_W     = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    overflow,
    output logic                    disp_update
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       bin_q, bin_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
    logic                    ovf_q, ovf_d;
    logic [7*NUM_DIGITS-1:0] seg_raw, hex_d, hex_q;
    logic                    overflow_q, disp_update_q;
    logic                    accept, last_shift;

    assign accept     = in_valid && in_ready;
    assign last_shift = (cnt_q == CNT_W'(DATA_W - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // ---------------- double-dabble datapath ----------------
    // Add-3 correction on every nibble >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    bin_d = in_data;
                    bcd_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                // A 1 leaving the top nibble means the value needs more
                // digits than we have; the flag stays set for this value.
                bin_d = bin_q << 1;
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
                ovf_d = ovf_q | bcd_adj[BCD_W-1];
                cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    // ---------------- segment encoding ----------------
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_enc
        seg7_digit_encode u_enc (
            .digit_i (bcd_q[4*k +: 4]),
            .seg_o   (seg_raw[7*k +: 7])
        );
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead_zero;
`endif

    always_comb begin
        hex_d = seg_raw;
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero = 1'b1;
`endif
        if (ovf_q) begin
            hex_d = {NUM_DIGITS{SEG_DASH}};
        end
`ifdef LEADING_ZERO_BLANK_EN
        else begin
            // Walk down from the top digit; blank while everything above
            // (and including) this digit is zero. Digit 0 is never blanked.
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                lead_zero = lead_zero & (bcd_q[4*k +: 4] == 4'd0);
                if (lead_zero) begin
                    hex_d[7*k +: 7] = SEG_BLANK;
                end
            end
        end
`endif
    end

    // Display registers change only in LOAD, so partial results never show.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_q         <= {NUM_DIGITS{SEG_BLANK}};
            overflow_q    <= 1'b0;
            disp_update_q <= 1'b0;
        end else begin
            disp_update_q <= (state_q == LOAD);
            if (state_q == LOAD) begin
                hex_q      <= hex_d;
                overflow_q <= ovf_q;
            end
        end
    end

    assign hex         = hex_q;
    assign overflow    = overflow_q;
    assign disp_update = disp_update_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver (DATA_W=20, NUM_DIGITS=6).
// Expected displays come from a decimal reference model using integer
// division and power-of-ten comparisons.
module tb_bcd_display_driver;

    localparam int DATA_W     = 20;
    localparam int NUM_DIGITS = 6;
    localparam int HEX_W      = 7 * NUM_DIGITS;
    localparam int LATENCY    = DATA_W + 1;
    localparam int MAX_VAL    = 999999;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic [HEX_W-1:0]  hex;
    logic              overflow;
    logic              disp_update;

    int checks   = 0;
    int failures = 0;

    bcd_display_driver #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .hex         (hex),
        .overflow    (overflow),
        .disp_update (disp_update)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [HEX_W-1:0] model_hex(input int v);
        logic [HEX_W-1:0] r;
        int rem;
        r = '0;
        if (v > MAX_VAL) begin
            for (int k = 0; k < NUM_DIGITS; k++) r[7*k +: 7] = 7'h3F;
            return r;
        end
        rem = v;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            r[7*k +: 7] = seg_of(rem % 10);
            rem = rem / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (v < 10 ** k) r[7*k +: 7] = 7'h7F;
        end
`endif
        return r;
    endfunction

    // Presents v, optionally keeps in_valid high with busy_val during the
    // conversion, and returns the edge count from acceptance to disp_update.
    // The display must not move before disp_update.
    task automatic convert(input int v, input bit hold_busy, input int busy_val,
                           output int lat);
        logic [HEX_W-1:0] prev_hex;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_accept value=%0d got=%b want=1", v, in_ready);
        end
        prev_hex = hex;
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        @(posedge clk); #1;
        if (hold_busy) in_data = DATA_W'(busy_val);
        else           in_valid = 1'b0;
        lat = 0;
        while (disp_update !== 1'b1 && lat < 100) begin
            checks++;
            if (hex !== prev_hex) begin
                failures++;
                $display("FAIL hex_stable value=%0d edge=%0d got=%h want=%h", v, lat, hex, prev_hex);
            end
            if (hold_busy) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL ready_busy value=%0d edge=%0d got=%b want=0", v, lat, in_ready);
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat != LATENCY) begin
            failures++;
            $display("FAIL latency value=%0d got=%0d want=%0d", v, lat, LATENCY);
        end
    endtask

    // Checks the display after convert() returned, plus pulse width.
    task automatic check_display(input string name, input int v);
        logic [HEX_W-1:0] exp_hex;
        logic             exp_ovf;
        exp_hex = model_hex(v);
        exp_ovf = (v > MAX_VAL);
        checks++;
        if (hex !== exp_hex) begin
            failures++;
            $display("FAIL %s_hex value=%0d got=%h want=%h", name, v, hex, exp_hex);
        end
        checks++;
        if (overflow !== exp_ovf) begin
            failures++;
            $display("FAIL %s_overflow value=%0d got=%b want=%b", name, v, overflow, exp_ovf);
        end
        @(posedge clk); #1;
        checks++;
        if (disp_update !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_pulse value=%0d got upd=%b rdy=%b want upd=0 rdy=1",
                     name, v, disp_update, in_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hex !== {NUM_DIGITS{7'h7F}} || overflow !== 1'b0 || disp_update !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got hex=%h ovf=%b upd=%b want hex=all7F ovf=0 upd=0",
                     hex, overflow, disp_update);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_directed();
        int lat;
        int vals[6];
        vals = '{0, 4096, 999999, 1000000, 7, 1048575};
        foreach (vals[i]) begin
            convert(vals[i], 1'b0, 0, lat);
            check_display("directed", vals[i]);
        end
    endtask

    task automatic test_busy_ignored();
        int lat;
        convert(555, 1'b1, 123, lat);
        check_display("busy", 555);
    endtask

    task automatic test_random();
        int lat;
        int v;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(999990, 1000010);
                default: v = $urandom_range(0, (1 << DATA_W) - 1);
            endcase
            convert(v, 1'b0, 0, lat);
            check_display("random", v);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        // convert() drives on the first negedge after the previous pulse,
        // i.e. the earliest acceptance edge.
        convert(31, 1'b0, 0, lat);
        convert(86420, 1'b0, 0, lat);
        check_display("b2b", 86420);
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        int seen_upd;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = DATA_W'(123456);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (hex !== {NUM_DIGITS{7'h7F}} || overflow !== 1'b0 || disp_update !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got hex=%h ovf=%b upd=%b want hex=all7F ovf=0 upd=0",
                     hex, overflow, disp_update);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen_upd = 0;
        for (int i = 0; i < LATENCY + 3; i++) begin
            @(posedge clk); #1;
            if (disp_update === 1'b1) seen_upd++;
        end
        checks++;
        if (seen_upd != 0 || hex !== {NUM_DIGITS{7'h7F}}) begin
            failures++;
            $display("FAIL midreset_quiet got upd_count=%0d hex=%h want 0 and all7F", seen_upd, hex);
        end
        convert(2024, 1'b0, 0, lat);
        check_display("after_reset", 2024);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_directed();
        test_busy_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
